// File: rtl/sqw_pkg.sv
// Shared definitions for the square wave analyzer: nominal half-period table,
// FSM encoding and the half-period to frequency-code matcher.
package sqw_pkg;

    localparam int NUM_CODES = 8;

    // Nominal half-period in clock cycles per frequency code (generator threshold + 1)
    localparam logic [15:0] NOM_HALF_PERIOD [0:NUM_CODES-1] = '{
        16'd391, 16'd196, 16'd131, 16'd99, 16'd66, 16'd50, 16'd33, 16'd25
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] code;
    } match_t;

    // Lowest code whose nominal half-period lies within tol of n
    function automatic match_t match_code(input logic [15:0] n, input logic [15:0] tol);
        match_t      m;
        logic [15:0] diff;
        m = '0;
        for (int i = NUM_CODES - 1; i >= 0; i--) begin
            diff = (n >= NOM_HALF_PERIOD[i]) ? (n - NOM_HALF_PERIOD[i])
                                             : (NOM_HALF_PERIOD[i] - n);
            if (diff <= tol) begin
                m.hit  = 1'b1;
                m.code = 3'(i);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/sqw_level_slicer.sv
// Hysteresis slicer: turns the 8-bit sampled waveform into a binary level and
// strobes edge_stb combinationally on the cycle the level is about to change.
module sqw_level_slicer #(
    parameter logic [7:0] HI_TH = 8'd192,
    parameter logic [7:0] LO_TH = 8'd64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] wave_in,
    output logic       level,
    output logic       edge_stb
);

    logic level_next;

    // Values strictly between the thresholds hold the previous level
    always_comb begin
        level_next = level;
        if (wave_in >= HI_TH)
            level_next = 1'b1;
        else if (wave_in <= LO_TH)
            level_next = 1'b0;
    end

    assign edge_stb = (level_next != level);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            level <= 1'b0;
        else
            level <= level_next;
    end

endmodule

// File: rtl/square_wave_analyzer.sv
// Measures the half-period of a sliced square wave, decodes it back to the
// generator's frequency code and tracks lock across consecutive measurements.
module square_wave_analyzer
    import sqw_pkg::*;
#(
    parameter logic [7:0]  HI_TH      = 8'd192,
    parameter logic [7:0]  LO_TH      = 8'd64,
    parameter int          TOL        = 4,
    parameter int          LOCK_COUNT = 4,
    parameter logic [15:0] TIMEOUT    = 16'd1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  wave_in,
    output logic [15:0] half_period,
    output logic        meas_valid,
    output logic        code_hit,
    output logic [2:0]  freq_code,
    output logic        locked,
    output logic        timeout
);

    localparam logic [15:0] TOL_W  = 16'(TOL);
    localparam logic [3:0]  LOCK_N = 4'(LOCK_COUNT);

    logic        level;
    logic        edge_stb;
    logic [15:0] cnt;
    logic [3:0]  match_cnt;
    logic [3:0]  match_inc;
    logic [2:0]  candidate;
    state_t      state;
    match_t      m;

    sqw_level_slicer #(
        .HI_TH (HI_TH),
        .LO_TH (LO_TH)
    ) u_slicer (
        .clk      (clk),
        .reset    (reset),
        .wave_in  (wave_in),
        .level    (level),
        .edge_stb (edge_stb)
    );

    // cnt holds the cycles since the last edge, so it is the interval when the next edge lands
    assign m = match_code(cnt, TOL_W);

    always_comb begin
        match_inc = 4'd1;
        if (m.code == candidate)
            match_inc = (match_cnt == 4'hF) ? 4'hF : match_cnt + 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            match_cnt   <= '0;
            candidate   <= '0;
            state       <= IDLE;
            half_period <= '0;
            meas_valid  <= 1'b0;
            code_hit    <= 1'b0;
            freq_code   <= '0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            code_hit   <= 1'b0;

            if (edge_stb)
                cnt <= 16'd1;
            else if (cnt < TIMEOUT)
                cnt <= cnt + 16'd1;

            case (state)
                IDLE: begin
                    // Reference edge only; the interval ending here is unknown
                    if (edge_stb) begin
                        timeout <= 1'b0;
                        state   <= MEASURE;
                    end
                end

                MEASURE: begin
                    if (edge_stb) begin
                        meas_valid  <= 1'b1;
                        half_period <= cnt;
                        code_hit    <= m.hit;
                        if (m.hit) begin
                            candidate <= m.code;
                            match_cnt <= match_inc;
                            if (match_inc >= LOCK_N) begin
                                locked    <= 1'b1;
                                freq_code <= m.code;
                                state     <= LOCKED;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end else if (cnt >= TIMEOUT) begin
                        timeout   <= 1'b1;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                        state     <= IDLE;
                    end
                end

                LOCKED: begin
                    if (edge_stb) begin
                        meas_valid  <= 1'b1;
                        half_period <= cnt;
                        code_hit    <= m.hit;
                        if (!(m.hit && m.code == candidate)) begin
                            // freq_code keeps the last locked value while re-acquiring
                            locked <= 1'b0;
                            state  <= MEASURE;
                            if (m.hit) begin
                                candidate <= m.code;
                                match_cnt <= 4'd1;
                            end else begin
                                match_cnt <= '0;
                            end
                        end
                    end else if (cnt >= TIMEOUT) begin
                        timeout   <= 1'b1;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_square_wave_analyzer.sv
// Directed bench for square_wave_analyzer: table of edge intervals with expected
// outputs, plus hand-written noise, timeout and mid-period reset sequences.
module tb_square_wave_analyzer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  wave_in;
    logic [15:0] half_period;
    logic        meas_valid;
    logic        code_hit;
    logic [2:0]  freq_code;
    logic        locked;
    logic        timeout;

    always #20 clk = ~clk;

    // TOL=3 keeps neighbouring match windows disjoint
    square_wave_analyzer #(.TOL(3), .LOCK_COUNT(4), .TIMEOUT(16'd1023)) dut (
        .clk         (clk),
        .reset       (reset),
        .wave_in     (wave_in),
        .half_period (half_period),
        .meas_valid  (meas_valid),
        .code_hit    (code_hit),
        .freq_code   (freq_code),
        .locked      (locked),
        .timeout     (timeout)
    );

    typedef struct {
        int          gap;
        logic        mv;
        logic        hit;
        logic [15:0] hp;
        logic        lk;
        logic [2:0]  code;
        logic        to;
    } vec_t;

    vec_t tbl[$];
    int   row = 0;
    int   checks = 0;
    int   errors = 0;
    logic lvl;

    function automatic vec_t mk(int gap, logic mv, logic hit, logic [15:0] hp,
                                logic lk, logic [2:0] code, logic to);
        vec_t v;
        v.gap = gap; v.mv = mv; v.hit = hit; v.hp = hp;
        v.lk = lk; v.code = code; v.to = to;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " half_period"}, half_period, 16'd0);
        chk({tag, " meas_valid"}, 16'(meas_valid), 16'd0);
        chk({tag, " code_hit"}, 16'(code_hit), 16'd0);
        chk({tag, " freq_code"}, 16'(freq_code), 16'd0);
        chk({tag, " locked"}, 16'(locked), 16'd0);
        chk({tag, " timeout"}, 16'(timeout), 16'd0);
    endtask

    // Called at the negedge after the previous edge was sampled; the next edge
    // is sampled exactly v.gap cycles after the previous one.
    task automatic do_edge(input vec_t v, input int idx);
        logic  stray;
        string tag;
        stray = 1'b0;
        tag = $sformatf("row%0d", idx);
        repeat (v.gap - 1) begin
            @(negedge clk);
            if (meas_valid) stray = 1'b1;
        end
        lvl = ~lvl;
        wave_in = lvl ? 8'd255 : 8'd0;
        @(negedge clk);
        chk({tag, " quiet"}, 16'(stray), 16'd0);
        chk({tag, " meas_valid"}, 16'(meas_valid), 16'(v.mv));
        if (v.mv) begin
            chk({tag, " code_hit"}, 16'(code_hit), 16'(v.hit));
            chk({tag, " half_period"}, half_period, v.hp);
        end
        chk({tag, " locked"}, 16'(locked), 16'(v.lk));
        chk({tag, " freq_code"}, 16'(freq_code), 16'(v.code));
        chk({tag, " timeout"}, 16'(timeout), 16'(v.to));
    endtask

    task automatic run_rows(input int n);
        for (int k = 0; k < n; k++) begin
            do_edge(tbl[row], row);
            row++;
        end
    endtask

    initial begin
        logic stray;

        // Phase A: loopback at code 3, then code 7 with window boundaries
        tbl.push_back(mk(10, 0, 0, 0, 0, 0, 0));
        repeat (3) tbl.push_back(mk(99, 1, 1, 99, 0, 0, 0));
        tbl.push_back(mk(99, 1, 1, 99, 1, 3, 0));
        repeat (3) tbl.push_back(mk(27, 1, 1, 27, 0, 3, 0));
        tbl.push_back(mk(27, 1, 1, 27, 1, 7, 0));
        tbl.push_back(mk(28, 1, 1, 28, 1, 7, 0));
        tbl.push_back(mk(22, 1, 1, 22, 1, 7, 0));
        tbl.push_back(mk(29, 1, 0, 29, 0, 7, 0));
        repeat (3) tbl.push_back(mk(27, 1, 1, 27, 0, 7, 0));
        tbl.push_back(mk(27, 1, 1, 27, 1, 7, 0));
        tbl.push_back(mk(21, 1, 0, 21, 0, 7, 0));
        // Phase B (after noise): code 5 lock, then move to code 0
        tbl.push_back(mk(50, 0, 0, 0, 0, 7, 0));
        repeat (3) tbl.push_back(mk(50, 1, 1, 50, 0, 7, 0));
        tbl.push_back(mk(50, 1, 1, 50, 1, 5, 0));
        repeat (3) tbl.push_back(mk(391, 1, 1, 391, 0, 5, 0));
        tbl.push_back(mk(391, 1, 1, 391, 1, 0, 0));
        // Phase C (after timeout): relock code 0, then switch to code 1
        tbl.push_back(mk(5, 0, 0, 0, 0, 0, 0));
        repeat (3) tbl.push_back(mk(391, 1, 1, 391, 0, 0, 0));
        tbl.push_back(mk(391, 1, 1, 391, 1, 0, 0));
        repeat (3) tbl.push_back(mk(196, 1, 1, 196, 0, 0, 0));
        tbl.push_back(mk(196, 1, 1, 196, 1, 1, 0));
        // Phase D (after reset): discard, then 4 fresh measurements
        tbl.push_back(mk(10, 0, 0, 0, 0, 0, 0));
        repeat (3) tbl.push_back(mk(196, 1, 1, 196, 0, 0, 0));
        tbl.push_back(mk(196, 1, 1, 196, 1, 1, 0));

        reset = 1'b1;
        wave_in = 8'd0;
        lvl = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;

        run_rows(17);

        // Mid-band noise never moves the level; the idle interval times out
        stray = 1'b0;
        repeat (2000) begin
            wave_in = 8'($urandom_range(70, 180));
            @(negedge clk);
            if (meas_valid) stray = 1'b1;
        end
        chk("noise quiet", 16'(stray), 16'd0);
        chk("noise timeout", 16'(timeout), 16'd1);
        chk("noise locked", 16'(locked), 16'd0);

        run_rows(9);

        // Freeze the wave while locked on code 0
        stray = 1'b0;
        repeat (1022) begin
            @(negedge clk);
            if (meas_valid) stray = 1'b1;
        end
        chk("freeze quiet", 16'(stray), 16'd0);
        chk("to pre timeout", 16'(timeout), 16'd0);
        chk("to pre locked", 16'(locked), 16'd1);
        @(negedge clk);
        chk("to timeout", 16'(timeout), 16'd1);
        chk("to locked", 16'(locked), 16'd0);
        chk("to freq_code", 16'(freq_code), 16'd0);

        run_rows(9);

        // Reset mid-period while locked on code 1: outputs clear before any clock edge
        repeat (30) @(negedge clk);
        #5;
        reset = 1'b1;
        wave_in = 8'd0;
        lvl = 1'b0;
        #1;
        chk_all_zero("async reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_rows(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
